// File: rtl/clk_en_gen_pkg.sv
// Types shared by the clock-enable generator and its lanes.
// Also holds the config-write legality check.
package clk_en_gen_pkg;

  localparam int CFG_CH_W  = 8;
  localparam int CFG_DIV_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [CFG_CH_W-1:0]  ch;
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_DIV_W-1:0] phase;
  } clk_en_cfg_t;

  function automatic logic cfg_bad(
    input int unsigned ch,
    input int unsigned div,
    input int unsigned phase,
    input int unsigned num
  );
    return (ch >= num) || ((div != 0) && (phase >= div));
  endfunction

endpackage

// File: rtl/tb_param.sv
// Shared elaboration constants for the clock-enable fabric.
package tb_param;
  localparam int NUM_CLK_EN = 4;
endpackage

// File: rtl/clk_en_ch.sv
// One enable lane: IDLE/ACTIVE FSM with a reloading down-counter.
// Pending config is taken while idle or at the lane's wrap.
module clk_en_ch
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_apply,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_phase,
  output logic             o_ack,
  output logic             o_clk_en,
  output logic             o_active
);

  ch_state_e        r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_cnt;
  logic             r_en;

  logic             w_wrap;
  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] w_phase;

  assign w_wrap  = (r_state == ACTIVE) && (r_cnt == '0);
  assign o_ack   = i_apply && ((r_state == IDLE) || w_wrap);
  assign w_div   = o_ack ? i_div   : r_div;
  assign w_phase = o_ack ? i_phase : r_phase;

  assign o_clk_en = r_en;
  assign o_active = (r_state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_phase <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_div   <= w_div;
      r_phase <= w_phase;
      unique case (r_state)
        IDLE: begin
          r_en <= 1'b0;
          if (i_run && (w_div != '0)) begin
            r_state <= ACTIVE;
            r_cnt   <= w_phase;
          end
        end
        ACTIVE: begin
          if (!i_run) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_cnt   <= '0;
          end else if (w_wrap) begin
            r_en <= 1'b1;
            // div=0 at the wrap: emit this pulse, then park
            if (w_div == '0) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_div - DIV_W'(1);
            end
          end else begin
            r_en  <= 1'b0;
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Programmable per-lane clock-enable generator with a single
// validated config slot shared by all lanes.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CLK_EN = tb_param::NUM_CLK_EN,
  parameter int DIV_W      = CFG_DIV_W,
  parameter int CH_W       = (NUM_CLK_EN > 1) ? $clog2(NUM_CLK_EN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLK_EN-1:0] clk_en,
  output logic [NUM_CLK_EN-1:0] ch_active,
  output logic                  cfg_err
);

  clk_en_cfg_t           r_slot;
  logic                  r_slot_vld;
  logic                  r_err;

  logic                  w_fire;
  logic                  w_bad;
  logic [NUM_CLK_EN-1:0] w_ack;

  assign cfg_ready = !r_slot_vld;
  assign cfg_err   = r_err;
  assign w_fire    = cfg_valid && cfg_ready;
  assign w_bad     = cfg_bad(32'(cfg_ch), 32'(cfg_div),
                             32'(cfg_phase), NUM_CLK_EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld <= 1'b0;
      r_slot     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_fire && w_bad;
      if (w_fire && !w_bad) begin
        r_slot_vld <= 1'b1;
        r_slot     <= '{ch:    CFG_CH_W'(cfg_ch),
                        div:   CFG_DIV_W'(cfg_div),
                        phase: CFG_DIV_W'(cfg_phase)};
      end else if (|w_ack) begin
        r_slot_vld <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CLK_EN; g++) begin : g_lane
    clk_en_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_run    (run),
      .i_apply  (r_slot_vld && (r_slot.ch == CFG_CH_W'(g))),
      .i_div    (DIV_W'(r_slot.div)),
      .i_phase  (DIV_W'(r_slot.phase)),
      .o_ack    (w_ack[g]),
      .o_clk_en (clk_en[g]),
      .o_active (ch_active[g])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen.
module tb_clk_en_gen;

  localparam int NUM = 4;
  localparam int DW  = 8;
  localparam int CW  = 3;

  logic           clk;
  logic           rst_n;
  logic           run;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [DW-1:0]  cfg_phase;
  logic [NUM-1:0] clk_en;
  logic [NUM-1:0] ch_active;
  logic           cfg_err;

  int cmp  = 0;
  int errs = 0;

  clk_en_gen #(
    .NUM_CLK_EN (NUM),
    .DIV_W      (DW),
    .CH_W       (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .clk_en    (clk_en),
    .ch_active (ch_active),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int ph);
    int n = 0;
    while (!cfg_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (cfg_ready !== 1'b1) begin
      $display("FAIL cfg_write_wait ready=%b required 1", cfg_ready);
      errs++;
    end
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    cmp++;
    if ({clk_en, ch_active, cfg_err, cfg_ready} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
      $display("FAIL reset_hold en=%h act=%h err=%b rdy=%b required 0/0/0/1",
               clk_en, ch_active, cfg_err, cfg_ready);
      errs++;
    end
    rst_n = 1'b1;
    tick(2);
    cmp++;
    if ({clk_en, ch_active, cfg_err, cfg_ready} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
      $display("FAIL reset_release en=%h act=%h err=%b rdy=%b required 0/0/0/1",
               clk_en, ch_active, cfg_err, cfg_ready);
      errs++;
    end
  endtask

  task automatic test_basic_div;
    logic [12:0] m0;
    logic [12:0] m1;
    m0 = 13'h0222;
    m1 = 13'h1248;
    cfg_write(0, 4, 0);
    cfg_write(1, 3, 2);
    tick(2);
    run = 1'b1;
    @(negedge clk);
    cmp++;
    if (ch_active[1:0] !== 2'b11 || clk_en[1:0] !== 2'b00) begin
      $display("FAIL basic_start act=%b en=%b required 11/00",
               ch_active[1:0], clk_en[1:0]);
      errs++;
    end
    for (int off = 1; off <= 12; off++) begin
      @(negedge clk);
      cmp++;
      if (clk_en[1:0] !== {m1[off], m0[off]}) begin
        $display("FAIL basic_off%0d en=%b required %b",
                 off, clk_en[1:0], {m1[off], m0[off]});
        errs++;
      end
    end
  endtask

  task automatic test_stop_restart;
    logic [3:0] e0;
    logic [3:0] e1;
    e0 = 4'b0010;
    e1 = 4'b1000;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp++;
      if (clk_en[1:0] !== 2'b00 || ch_active[1:0] !== 2'b00) begin
        $display("FAIL stop_%0d en=%b act=%b required 00/00",
                 i, clk_en[1:0], ch_active[1:0]);
        errs++;
      end
    end
    run = 1'b1;
    @(negedge clk);
    cmp++;
    if (ch_active[1:0] !== 2'b11) begin
      $display("FAIL restart_act act=%b required 11", ch_active[1:0]);
      errs++;
    end
    for (int off = 1; off <= 3; off++) begin
      @(negedge clk);
      cmp++;
      if (clk_en[1:0] !== {e1[off], e0[off]}) begin
        $display("FAIL restart_off%0d en=%b required %b",
                 off, clk_en[1:0], {e1[off], e0[off]});
        errs++;
      end
    end
    run = 1'b0;
    tick(2);
  endtask

  task automatic test_hold_high;
    cfg_write(2, 1, 0);
    cfg_write(3, 0, 0);
    tick(2);
    run = 1'b1;
    @(negedge clk);
    cmp++;
    if (ch_active[3:2] !== 2'b01 || clk_en[2] !== 1'b0) begin
      $display("FAIL hold_start act=%b en2=%b required 01/0",
               ch_active[3:2], clk_en[2]);
      errs++;
    end
    for (int off = 1; off <= 6; off++) begin
      @(negedge clk);
      cmp++;
      if (clk_en[3:2] !== 2'b01 || ch_active[3] !== 1'b0) begin
        $display("FAIL hold_off%0d en=%b act3=%b required 01/0",
                 off, clk_en[3:2], ch_active[3]);
        errs++;
      end
    end
    run = 1'b0;
    @(negedge clk);
    cmp++;
    if (clk_en !== 4'h0 || ch_active !== 4'h0) begin
      $display("FAIL hold_stop en=%h act=%h required 0/0", clk_en, ch_active);
      errs++;
    end
    tick(1);
  endtask

  task automatic test_mid_update;
    logic [11:0] m;
    m = 12'b1010_1010_0010;
    run = 1'b1;
    for (int off = 0; off <= 11; off++) begin
      @(negedge clk);
      if (off == 3) cfg_valid = 1'b0;
      cmp++;
      if (clk_en[0] !== m[off]) begin
        $display("FAIL update_off%0d en0=%b required %b",
                 off, clk_en[0], m[off]);
        errs++;
      end
      if (off == 3 || off == 4 || off == 5) begin
        cmp++;
        if (cfg_ready !== (off == 5)) begin
          $display("FAIL update_ready_off%0d ready=%b required %b",
                   off, cfg_ready, (off == 5));
          errs++;
        end
      end
      if (off == 2) begin
        cfg_ch    = 3'd0;
        cfg_div   = 8'd2;
        cfg_phase = 8'd0;
        cfg_valid = 1'b1;
      end
    end
    run = 1'b0;
    tick(2);
  endtask

  task automatic test_reject;
    logic [5:0] m;
    m = 6'b101010;
    for (int r = 0; r < 2; r++) begin
      cfg_ch    = (r == 0) ? 3'd4 : 3'd0;
      cfg_div   = (r == 0) ? 8'd5 : 8'd3;
      cfg_phase = (r == 0) ? 8'd0 : 8'd3;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      cmp++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
        $display("FAIL reject%0d_pulse err=%b rdy=%b required 1/1",
                 r, cfg_err, cfg_ready);
        errs++;
      end
      @(negedge clk);
      cmp++;
      if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
        $display("FAIL reject%0d_after err=%b rdy=%b required 0/1",
                 r, cfg_err, cfg_ready);
        errs++;
      end
    end
    run = 1'b1;
    for (int off = 0; off <= 5; off++) begin
      @(negedge clk);
      cmp++;
      if (clk_en[0] !== m[off]) begin
        $display("FAIL reject_lane_off%0d en0=%b required %b",
                 off, clk_en[0], m[off]);
        errs++;
      end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if (clk_en !== 4'h0 || ch_active !== 4'h0 ||
        cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      $display("FAIL areset_now en=%h act=%h err=%b rdy=%b required 0/0/0/1",
               clk_en, ch_active, cfg_err, cfg_ready);
      errs++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp++;
      if (clk_en !== 4'h0 || ch_active !== 4'h0 || cfg_ready !== 1'b1) begin
        $display("FAIL areset_after%0d en=%h act=%h rdy=%b required 0/0/1",
                 i, clk_en, ch_active, cfg_ready);
        errs++;
      end
    end
    run = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    @(negedge clk);
    test_reset;
    test_basic_div;
    test_stop_restart;
    test_hold_high;
    test_mid_update;
    test_reject;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
